// File: rtl/captura_pkg.sv
// Shared definitions for the symbol capture stage and the downstream symbol-sequence machine.
// State encodings, the six legal symbol codes and the default debounce length live here.
package captura_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PRESS    = 3'd1;
   localparam logic [2:0] ST_STROBE   = 3'd2;
   localparam logic [2:0] ST_WAIT_REL = 3'd3;
   localparam logic [2:0] ST_RELEASE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      PRESS    = ST_PRESS,
      STROBE   = ST_STROBE,
      WAIT_REL = ST_WAIT_REL,
      RELEASE  = ST_RELEASE
   } estado_t;

   localparam logic [6:0] SIMBOLO_0 = 7'b0010000;
   localparam logic [6:0] SIMBOLO_1 = 7'b0100100;
   localparam logic [6:0] SIMBOLO_2 = 7'b0000010;
   localparam logic [6:0] SIMBOLO_3 = 7'b1000111;
   localparam logic [6:0] SIMBOLO_4 = 7'b0111010;
   localparam logic [6:0] SIMBOLO_5 = 7'b0101001;

   localparam int DEBOUNCE_CYCLES_DEF = 16;

   // True when the code is one of the six symbols the downstream machine understands.
   function automatic logic es_simbolo_valido(input logic [6:0] s);
      logic r;
      r = 1'b0;
      if (s == SIMBOLO_0 || s == SIMBOLO_1 || s == SIMBOLO_2 ||
          s == SIMBOLO_3 || s == SIMBOLO_4 || s == SIMBOLO_5)
         r = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer of configurable width, asynchronous active-high reset.
// Each bit is synchronized independently; no multi-bit coherency is implied.
module sincronizador #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         res,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/captura_simbolo.sv
// Switch/button capture stage: synchronizes inputs, debounces press and release, emits codigo + ctrl.
// Optional symbol filtering is enabled with `define CAPTURA_FILTRO_SIMBOLO_EN.
module captura_simbolo
   import captura_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       res,
   input  logic [6:0] sw_raw,
   input  logic       btn_raw,
   output logic [6:0] codigo,
   output logic       ctrl,
   output logic       busy,
   output logic       invalido
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [6:0]       sw_s;
   logic             btn_s;
   estado_t          estado, estado_sig;
   logic [CNT_W-1:0] cnt, cnt_sig;
   logic [6:0]       codigo_sig;
   logic             ctrl_sig;

   sincronizador #(.W(7)) u_sinc_sw (
      .clk (clk),
      .res (res),
      .d   (sw_raw),
      .q   (sw_s)
   );

   sincronizador #(.W(1)) u_sinc_btn (
      .clk (clk),
      .res (res),
      .d   (btn_raw),
      .q   (btn_s)
   );

`ifdef CAPTURA_FILTRO_SIMBOLO_EN
   logic invalido_q, invalido_sig;
`endif

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         estado <= IDLE;
         cnt    <= '0;
         codigo <= '0;
         ctrl   <= 1'b0;
`ifdef CAPTURA_FILTRO_SIMBOLO_EN
         invalido_q <= 1'b0;
`endif
      end else begin
         estado <= estado_sig;
         cnt    <= cnt_sig;
         codigo <= codigo_sig;
         ctrl   <= ctrl_sig;
`ifdef CAPTURA_FILTRO_SIMBOLO_EN
         invalido_q <= invalido_sig;
`endif
      end
   end

   // Strobes default low every cycle, so ctrl/invalido are single-cycle by construction.
   always_comb begin
      estado_sig = estado;
      cnt_sig    = cnt;
      codigo_sig = codigo;
      ctrl_sig   = 1'b0;
`ifdef CAPTURA_FILTRO_SIMBOLO_EN
      invalido_sig = 1'b0;
`endif
      case (estado)
         IDLE: begin
            if (btn_s) begin
               estado_sig = PRESS;
               cnt_sig    = '0;
            end
         end
         PRESS: begin
            if (!btn_s) begin
               estado_sig = IDLE;
            end else if (cnt == CNT_MAX) begin
`ifdef CAPTURA_FILTRO_SIMBOLO_EN
               if (es_simbolo_valido(sw_s)) begin
                  codigo_sig = sw_s;
                  ctrl_sig   = 1'b1;
               end else begin
                  invalido_sig = 1'b1;
               end
`else
               codigo_sig = sw_s;
               ctrl_sig   = 1'b1;
`endif
               estado_sig = STROBE;
            end else begin
               cnt_sig = cnt + CNT_W'(1);
            end
         end
         STROBE: begin
            estado_sig = WAIT_REL;
         end
         WAIT_REL: begin
            if (!btn_s) begin
               estado_sig = RELEASE;
               cnt_sig    = '0;
            end
         end
         RELEASE: begin
            if (btn_s) begin
               estado_sig = WAIT_REL;
            end else if (cnt == CNT_MAX) begin
               estado_sig = IDLE;
            end else begin
               cnt_sig = cnt + CNT_W'(1);
            end
         end
         default: begin
            estado_sig = IDLE;
            cnt_sig    = '0;
         end
      endcase
   end

   assign busy = (estado != IDLE);

`ifdef CAPTURA_FILTRO_SIMBOLO_EN
   assign invalido = invalido_q;
`else
   assign invalido = 1'b0;
`endif

endmodule

// File: tb/tb_captura_simbolo.sv
// Scoreboard bench for captura_simbolo with DEBOUNCE_CYCLES=4: stimulus pushes expected strobes,
// a negedge monitor pops and checks them; covers the filtered-symbol case when CAPTURA_FILTRO_SIMBOLO_EN is set.
module tb_captura_simbolo;

   localparam int D = 4;

   typedef struct {
      bit         inval;
      logic [6:0] codigo;
      int         cyc;
   } esperado_t;

   logic       clk;
   logic       res;
   logic [6:0] sw_raw;
   logic       btn_raw;
   logic [6:0] codigo;
   logic       ctrl;
   logic       busy;
   logic       invalido;

   int        n_checks;
   int        n_fails;
   int        cyc;
   int        e0;
   int        r0;
   esperado_t sb[$];

   captura_simbolo #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
      .clk      (clk),
      .res      (res),
      .sw_raw   (sw_raw),
      .btn_raw  (btn_raw),
      .codigo   (codigo),
      .ctrl     (ctrl),
      .busy     (busy),
      .invalido (invalido)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Holds the given input levels for n cycles; always entered and left on a falling edge.
   task automatic applyStimulus(input logic b, input logic [6:0] s, input int n);
      btn_raw = b;
      sw_raw  = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic expectStrobe(input bit inval, input logic [6:0] c, input int at);
      esperado_t e;
      e.inval  = inval;
      e.codigo = c;
      e.cyc    = at;
      sb.push_back(e);
   endtask

   // Every ctrl or invalido pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (!res && (ctrl || invalido)) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_strobe", {30'd0, ctrl, invalido}, 32'd0);
         end else begin
            esperado_t e;
            e = sb.pop_front();
            checkOutput("strobe_kind", {30'd0, ctrl, invalido}, e.inval ? 32'd1 : 32'd2);
            checkOutput("strobe_codigo", {25'd0, codigo}, {25'd0, e.codigo});
            checkOutput("strobe_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      n_checks = 0;
      n_fails  = 0;
      cyc      = 0;
      res      = 1'b1;
      btn_raw  = 1'b0;
      sw_raw   = 7'b0;
      repeat (3) @(negedge clk);
      res = 1'b0;

      $display("[TB] reset and idle");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("idle_codigo", {25'd0, codigo}, 32'd0);
         checkOutput("idle_ctrl", {31'd0, ctrl}, 32'd0);
         checkOutput("idle_busy", {31'd0, busy}, 32'd0);
      end

      $display("[TB] clean press");
      e0 = cyc + 1;
      expectStrobe(1'b0, 7'b0010000, e0 + D + 2);
      applyStimulus(1'b1, 7'b0010000, 30);
      checkOutput("clean_codigo_held", {25'd0, codigo}, {25'd0, 7'b0010000});
      checkOutput("clean_busy_held", {31'd0, busy}, 32'd1);
      r0 = cyc + 1;
      applyStimulus(1'b0, 7'b0010000, D + 2);
      checkOutput("clean_busy_release_end", {31'd0, busy}, 32'd1);
      applyStimulus(1'b0, 7'b0010000, 1);
      checkOutput("clean_busy_idle", {31'd0, busy}, 32'd0);
      checkOutput("clean_release_cycle", cyc, r0 + D + 2);
      checkOutput("clean_pending", sb.size(), 32'd0);

      $display("[TB] bouncing press");
      applyStimulus(1'b1, 7'b1000111, 1);
      applyStimulus(1'b0, 7'b1000111, 1);
      applyStimulus(1'b1, 7'b1000111, 1);
      applyStimulus(1'b0, 7'b1000111, 1);
      e0 = cyc + 1;
      expectStrobe(1'b0, 7'b1000111, e0 + D + 2);
      applyStimulus(1'b1, 7'b1000111, 20);
      applyStimulus(1'b0, 7'b1000111, 12);
      checkOutput("bounce_busy", {31'd0, busy}, 32'd0);
      checkOutput("bounce_pending", sb.size(), 32'd0);

      $display("[TB] switch change while held, release bounce");
      e0 = cyc + 1;
      expectStrobe(1'b0, 7'b0100100, e0 + D + 2);
      applyStimulus(1'b1, 7'b0100100, 12);
      applyStimulus(1'b1, 7'b0000010, 15);
      checkOutput("hold_codigo", {25'd0, codigo}, {25'd0, 7'b0100100});
      applyStimulus(1'b0, 7'b0000010, 1);
      applyStimulus(1'b1, 7'b0000010, 1);
      applyStimulus(1'b0, 7'b0000010, 1);
      applyStimulus(1'b1, 7'b0000010, 1);
      applyStimulus(1'b0, 7'b0000010, 12);
      checkOutput("relbounce_codigo", {25'd0, codigo}, {25'd0, 7'b0100100});
      checkOutput("relbounce_busy", {31'd0, busy}, 32'd0);
      checkOutput("relbounce_pending", sb.size(), 32'd0);

`ifdef CAPTURA_FILTRO_SIMBOLO_EN
      $display("[TB] rejected symbol");
      e0 = cyc + 1;
      expectStrobe(1'b1, 7'b0100100, e0 + D + 2);
      applyStimulus(1'b1, 7'b1111111, 12);
      applyStimulus(1'b0, 7'b1111111, 12);
      checkOutput("filter_codigo", {25'd0, codigo}, {25'd0, 7'b0100100});
      checkOutput("filter_busy", {31'd0, busy}, 32'd0);
      checkOutput("filter_pending", sb.size(), 32'd0);
`endif

      $display("[TB] reset during debounce");
      applyStimulus(1'b1, 7'b0111010, D + 1);
      checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
      #2;
      res = 1'b1;
      #1;
      checkOutput("abort_codigo", {25'd0, codigo}, 32'd0);
      checkOutput("abort_ctrl", {31'd0, ctrl}, 32'd0);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_invalido", {31'd0, invalido}, 32'd0);
      btn_raw = 1'b0;
      @(negedge clk);
      @(negedge clk);
      res = 1'b0;
      applyStimulus(1'b0, 7'b0111010, 20);
      checkOutput("abort_busy_after", {31'd0, busy}, 32'd0);
      checkOutput("abort_codigo_after", {25'd0, codigo}, 32'd0);
      checkOutput("final_pending", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/captura_simbolo.md
Name: captura_simbolo

Overview:
- Upstream input stage for the symbol-sequence state machine.
- Takes a raw 7-bit switch bank and a raw "enter" push-button, and synchronizes both into the clk domain.
- Debounces the button on press and on release. On each confirmed press it presents a stable 7-bit symbol code and a one-cycle ctrl strobe, which the downstream machine consumes as its entrada/ctrl pair.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a press or a release. Legal range 2..255.
- CNT_W, 8: debounce counter width. Must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- res  in  1  asynchronous, active-high reset.
- sw_raw  in  7  raw switch bank; asynchronous to clk.
- btn_raw  in  1  raw enter button, active-high; asynchronous and bouncing.
- codigo  out  7  captured symbol code; drives the downstream entrada.
- ctrl  out  1  one-cycle strobe: codigo is new; drives the downstream ctrl.
- busy  out  1  high whenever the FSM is not in IDLE.
- invalido  out  1  one-cycle pulse when a captured code is rejected. Tied 0 without the optional feature.

Behaviour:
- Interface: one clock, clk; reset res is asynchronous and active-high.
- Reset values: codigo=7'b0000000, ctrl=0, busy=0, invalido=0, FSM=IDLE, counter=0, synchronizer flops=0.
- Reset asserted mid-operation aborts immediately. No strobe is emitted for a partially debounced press.
- Synchronization:
  - btn_raw and each sw_raw bit pass through two flops; the outputs are btn_s and sw_s.
  - All FSM decisions use btn_s and sw_s only.
- FSM states: IDLE, PRESS, STROBE, WAIT_REL, RELEASE.
  - IDLE: when btn_s=1, go to PRESS with cnt=0.
  - PRESS:
    - btn_s=0: go back to IDLE (bounce rejected).
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1: capture codigo<=sw_s, assert ctrl<=1, go to STROBE.
    - otherwise cnt<=cnt+1.
  - STROBE: ctrl<=0, go to WAIT_REL. This state lasts exactly 1 cycle.
  - WAIT_REL: when btn_s=0, go to RELEASE with cnt=0. No further strobes while the button is held.
  - RELEASE:
    - btn_s=1: go back to WAIT_REL (release bounce).
    - cnt==DEBOUNCE_CYCLES-1: go to IDLE.
    - otherwise cnt<=cnt+1.
- Latency: let edge 0 be the first posedge sampling btn_raw=1 with the button clean thereafter. ctrl is registered high at edge DEBOUNCE_CYCLES+2 and low at the next edge. Example: D=16 gives ctrl high after edge 18.
- Downstream timing: ctrl and codigo are posedge-registered and stable across the full cycle, so the downstream negedge-sampling machine sees ctrl=1 on exactly one falling edge.
- codigo holds its last captured value until the next capture. It is never cleared except by reset.
- sw_raw changes outside the capture edge have no effect on codigo.
- Counter never wraps; it is bounded by DEBOUNCE_CYCLES-1.
- Button held indefinitely produces exactly one strobe.

Optional Feature:
- Macro: CAPTURA_FILTRO_SIMBOLO_EN.
- Defined: at the capture edge, sw_s is compared against the symbol table 0010000, 0100100, 0000010, 1000111, 0111010, 0101001.
  - Match: normal behaviour.
  - No match: codigo unchanged, ctrl stays 0, invalido=1 for one cycle, FSM proceeds to STROBE/WAIT_REL as usual.
- Undefined: no filtering; invalido tied 0.

Decomposition:
- Package captura_pkg:
  - FSM state encoding (3-bit localparams).
  - The six 7-bit symbol-code constants, also used by the downstream machine.
  - Default DEBOUNCE_CYCLES.
- One sub-module, sincronizador: parameterized-width two-flop synchronizer with async active-high reset. It is instantiated once for the 7-bit bank and once for the button.

Test Plan (D=4 unless noted):
- Reset, then idle for 20 cycles: codigo=0000000, ctrl=0, busy=0 throughout.
- sw_raw=0010000, clean btn_raw press held 30 cycles: ctrl high for exactly one cycle after edge 6; codigo=0010000 from that edge; busy until 6 cycles after release.
- Button bounces 1,0,1,0 at 1-cycle spacing, then stable 1: no ctrl during the bounce; a single strobe 6 edges after the final stable rising sample.
- Press captures 0100100, sw_raw changes to 0000010 while held, release bounces twice: codigo stays 0100100; no second strobe; FSM returns to IDLE.
- res pulsed at PRESS cnt=2: outputs return to reset values immediately; ctrl never asserts for that press.
- With CAPTURA_FILTRO_SIMBOLO_EN, press with sw_raw=1111111: ctrl=0, invalido=1 for one cycle, codigo keeps its previous value 0100100.
